ariane_regfile_lvt_fpga: RTL and testbench



---
 rtl/ariane_regfile_lvt_fpga.sv | 169 ++++++++++++++++
 tb/tb_ariane_regfile_lvt_fpga.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ariane_regfile_lvt_fpga.sv
// Multi-port LVT register file for FPGA: one distributed-RAM bank per write port, LVT-steered reads,
// hardware clear sequencer. Optional same-cycle write-to-read bypass: ARIANE_REGFILE_FPGA_BYPASS_EN.
module ariane_regfile_lvt_fpga #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter int unsigned ZERO_REG_ZERO  = 0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         test_en_i,
  input  logic                                         clear_req_i,
  output logic                                         busy_o,
  input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]     raddr_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]     rdata_o,
  input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]    waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                    we_i
);

  localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;
  localparam int unsigned LVT_W     = (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_r, state_nx_s;
  logic [ADDR_WIDTH-1:0]   clr_cnt_r, clr_cnt_nx_s;
  logic                    busy_r, busy_nx_s;
  logic [LVT_W-1:0]        lvt_r [NUM_WORDS];

  logic [NR_WRITE_PORTS-1:0]                 wr_keep_s;
  logic [NR_WRITE_PORTS-1:0]                 bank_we_s;
  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] bank_waddr_s;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] bank_wdata_s;
  logic [DATA_WIDTH-1:0]                     bank_rdata_s [NR_WRITE_PORTS][NR_READ_PORTS];

  logic unused_s;
  assign unused_s = test_en_i;
  assign busy_o   = busy_r;

  // Next-state logic of the clear sequencer
  always_comb begin
    state_nx_s   = state_r;
    clr_cnt_nx_s = clr_cnt_r;
    busy_nx_s    = busy_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == {ADDR_WIDTH{1'b1}}) begin
          state_nx_s = ST_READY;
          busy_nx_s  = 1'b0;
        end else begin
          clr_cnt_nx_s = clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_READY: begin
        if (clear_req_i) begin
          state_nx_s   = ST_CLEAR;
          clr_cnt_nx_s = {ADDR_WIDTH{1'b0}};
          busy_nx_s    = 1'b1;
        end else begin
          busy_nx_s = 1'b0;
        end
      end
      default: begin
        state_nx_s   = ST_CLEAR;
        clr_cnt_nx_s = {ADDR_WIDTH{1'b0}};
        busy_nx_s    = 1'b1;
      end
    endcase
  end

  // Sequencer state, clear counter and registered busy flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_CLEAR;
      clr_cnt_r <= {ADDR_WIDTH{1'b0}};
      busy_r    <= 1'b1;
    end else begin
      state_r   <= state_nx_s;
      clr_cnt_r <= clr_cnt_nx_s;
      busy_r    <= busy_nx_s;
    end
  end

  // Functional write qualification: address-0 writes vanish when word 0 is hardwired
  always_comb begin
    for (int j = 0; j < NR_WRITE_PORTS; j++) begin
      if ((ZERO_REG_ZERO != 0) && (waddr_i[j] == {ADDR_WIDTH{1'b0}})) begin
        wr_keep_s[j] = 1'b0;
      end else begin
        wr_keep_s[j] = we_i[j];
      end
    end
  end

  // Bank write-port mux: the clear sequencer takes over every bank while clearing
  always_comb begin
    for (int j = 0; j < NR_WRITE_PORTS; j++) begin
      if (state_r == ST_CLEAR) begin
        bank_we_s[j]    = 1'b1;
        bank_waddr_s[j] = clr_cnt_r;
        bank_wdata_s[j] = {DATA_WIDTH{1'b0}};
      end else begin
        bank_we_s[j]    = wr_keep_s[j];
        bank_waddr_s[j] = waddr_i[j];
        bank_wdata_s[j] = wdata_i[j];
      end
    end
  end

  // Live-value table; ascending loop lets the highest port win on collisions
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        lvt_r[i] <= {LVT_W{1'b0}};
      end
    end else if (state_r == ST_CLEAR) begin
      lvt_r[clr_cnt_r] <= {LVT_W{1'b0}};
    end else begin
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
        if (wr_keep_s[j]) begin
          lvt_r[waddr_i[j]] <= LVT_W'(j);
        end
      end
    end
  end

  for (genvar gj = 0; gj < NR_WRITE_PORTS; gj++) begin : gen_bank
    logic [DATA_WIDTH-1:0] mem_r [NUM_WORDS];

    // Resetless single-write-port bank so it maps onto distributed RAM
    always_ff @(posedge clk_i) begin
      if (bank_we_s[gj]) begin
        mem_r[bank_waddr_s[gj]] <= bank_wdata_s[gj];
      end
    end

    for (genvar gk = 0; gk < NR_READ_PORTS; gk++) begin : gen_rd
      assign bank_rdata_s[gj][gk] = mem_r[raddr_i[gk]];
    end
  end

  // Read steering through the LVT; forced to zero while clearing
  always_comb begin
    for (int k = 0; k < NR_READ_PORTS; k++) begin
      rdata_o[k] = {DATA_WIDTH{1'b0}};
      if (!busy_r) begin
        rdata_o[k] = bank_rdata_s[lvt_r[raddr_i[k]]][k];
`ifdef ARIANE_REGFILE_FPGA_BYPASS_EN
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
          if (wr_keep_s[j] && (waddr_i[j] == raddr_i[k])) begin
            rdata_o[k] = wdata_i[j];
          end
        end
`endif
        if ((ZERO_REG_ZERO != 0) && (raddr_i[k] == {ADDR_WIDTH{1'b0}})) begin
          rdata_o[k] = {DATA_WIDTH{1'b0}};
        end
      end else begin
        rdata_o[k] = {DATA_WIDTH{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_ariane_regfile_lvt_fpga.sv
// Directed self-checking bench for ariane_regfile_lvt_fpga (default build and a ZERO_REG_ZERO=1 instance).
module tb_ariane_regfile_lvt_fpga;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             test_en_i;
  logic             clear_req_i;
  logic             busy_o, busy_z;
  logic [1:0][4:0]  raddr_i;
  logic [1:0][31:0] rdata_o, rdata_z;
  logic [1:0][4:0]  waddr_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0]       we_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ariane_regfile_lvt_fpga dut (
    .clk_i(clk_i), .rst_i(rst_i), .test_en_i(test_en_i), .clear_req_i(clear_req_i),
    .busy_o(busy_o), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i)
  );

  ariane_regfile_lvt_fpga #(.ZERO_REG_ZERO(1)) dut_z (
    .clk_i(clk_i), .rst_i(rst_i), .test_en_i(test_en_i), .clear_req_i(clear_req_i),
    .busy_o(busy_z), .raddr_i(raddr_i), .rdata_o(rdata_z),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i)
  );

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  // counts consecutive busy cycles starting at the current sample, bounded
  task automatic count_busy(input string name, input logic [1:0] we_during);
    int n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      we_i       = we_during;
      waddr_i[0] = 5'(n);
      waddr_i[1] = 5'(n + 3);
      wdata_i[0] = 32'hBAD0_0000 | n;
      wdata_i[1] = 32'hBAD1_0000 | n;
      raddr_i[0] = 5'd17;
      #1;
      total++;
      if (rdata_o[0] !== 32'h0) begin
        bad++;
        $display("FAIL %s_rd0_busy cyc=%0d got=%h exp=%h", name, n, rdata_o[0], 32'h0);
      end
      cycle();
    end
    we_i = 2'b00;
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL %s_busy_len got=%0d exp=%0d", name, n, 32);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      raddr_i[0] = 5'(a);
      raddr_i[1] = 5'(31 - a);
      #1;
      total++;
      if (rdata_o[0] !== 32'h0 || rdata_o[1] !== 32'h0) begin
        bad++;
        $display("FAIL %s a=%0d got=%h/%h exp=0/0", name, a, rdata_o[0], rdata_o[1]);
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=1", busy_o);
    end
    count_busy("reset", 2'b00);
    total++;
    if (busy_o !== 1'b0 || busy_z !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b/%b exp=0/0", busy_o, busy_z);
    end
    check_all_zero("reset_zero");
  endtask

  task automatic test_basic();
    we_i = 2'b11;
    waddr_i[0] = 5'd7;  wdata_i[0] = 32'hDEADBEEF;
    waddr_i[1] = 5'd9;  wdata_i[1] = 32'h12345678;
    cycle();
    we_i = 2'b00;
    raddr_i[0] = 5'd7;
    raddr_i[1] = 5'd9;
    #1;
    total++;
    if (rdata_o[0] !== 32'hDEADBEEF || rdata_o[1] !== 32'h12345678) begin
      bad++;
      $display("FAIL basic got=%h/%h exp=deadbeef/12345678", rdata_o[0], rdata_o[1]);
    end
  endtask

  task automatic test_collision();
    we_i = 2'b11;
    waddr_i[0] = 5'd3;  wdata_i[0] = 32'hAAAA0000;
    waddr_i[1] = 5'd3;  wdata_i[1] = 32'h5555FFFF;
    cycle();
    we_i = 2'b00;
    raddr_i[0] = 5'd3;
    raddr_i[1] = 5'd3;
    #1;
    total++;
    if (rdata_o[0] !== 32'h5555FFFF || rdata_o[1] !== 32'h5555FFFF) begin
      bad++;
      $display("FAIL collision got=%h/%h exp=5555ffff", rdata_o[0], rdata_o[1]);
    end
    we_i = 2'b01;
    waddr_i[0] = 5'd3;  wdata_i[0] = 32'h1;
    cycle();
    we_i = 2'b00;
    #1;
    total++;
    if (rdata_o[0] !== 32'h1) begin
      bad++;
      $display("FAIL collision_port0 got=%h exp=%h", rdata_o[0], 32'h1);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_now;
`ifdef ARIANE_REGFILE_FPGA_BYPASS_EN
    exp_now = 32'h20;
`else
    exp_now = 32'h10;
`endif
    we_i = 2'b10;
    waddr_i[1] = 5'd4;  wdata_i[1] = 32'h10;
    cycle();
    we_i = 2'b01;
    waddr_i[0] = 5'd4;  wdata_i[0] = 32'h20;
    raddr_i[0] = 5'd4;
    #1;
    total++;
    if (rdata_o[0] !== exp_now) begin
      bad++;
      $display("FAIL same_cycle_now got=%h exp=%h", rdata_o[0], exp_now);
    end
    cycle();
    we_i = 2'b00;
    #1;
    total++;
    if (rdata_o[0] !== 32'h20) begin
      bad++;
      $display("FAIL same_cycle_next got=%h exp=%h", rdata_o[0], 32'h20);
    end
  endtask

  task automatic test_zero_reg();
    we_i = 2'b01;
    waddr_i[0] = 5'd0;  wdata_i[0] = 32'hFFFFFFFF;
    raddr_i[1] = 5'd0;
    #1;
    total++;
    if (rdata_z[1] !== 32'h0) begin
      bad++;
      $display("FAIL zero_reg_bypass got=%h exp=0", rdata_z[1]);
    end
    cycle();
    we_i = 2'b00;
    raddr_i[0] = 5'd0;
    #1;
    total++;
    if (rdata_o[0] !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL zero_reg_plain got=%h exp=ffffffff", rdata_o[0]);
    end
    total++;
    if (rdata_z[0] !== 32'h0) begin
      bad++;
      $display("FAIL zero_reg_hard got=%h exp=0", rdata_z[0]);
    end
    raddr_i[0] = 5'd7;
    #1;
    total++;
    if (rdata_z[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL zero_reg_other got=%h exp=deadbeef", rdata_z[0]);
    end
  endtask

  task automatic test_clear_req();
    for (int a = 1; a < 32; a++) begin
      we_i = (a % 2 == 1) ? 2'b01 : 2'b10;
      waddr_i[a % 2 == 1 ? 0 : 1] = 5'(a);
      wdata_i[a % 2 == 1 ? 0 : 1] = 32'h1000_0000 | a;
      cycle();
    end
    we_i = 2'b00;
    raddr_i[0] = 5'd17;
    raddr_i[1] = 5'd30;
    #1;
    total++;
    if (rdata_o[0] !== 32'h1000_0011 || rdata_o[1] !== 32'h1000_001E) begin
      bad++;
      $display("FAIL fill got=%h/%h exp=10000011/1000001e", rdata_o[0], rdata_o[1]);
    end
    clear_req_i = 1'b1;
    cycle();
    clear_req_i = 1'b0;
    count_busy("clear_req", 2'b11);
    check_all_zero("clear_zero");
  endtask

  task automatic test_reset_mid_clear();
    we_i = 2'b01;
    waddr_i[0] = 5'd5;  wdata_i[0] = 32'h5;
    cycle();
    we_i = 2'b00;
    clear_req_i = 1'b1;
    cycle();
    clear_req_i = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    count_busy("mid_clear", 2'b00);
    check_all_zero("mid_clear_zero");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;  test_en_i = 1'b0;  clear_req_i = 1'b0;
    raddr_i = '0;  waddr_i = '0;  wdata_i = '0;  we_i = 2'b00;
    test_reset();
    test_basic();
    test_collision();
    test_same_cycle();
    test_zero_reg();
    test_clear_req();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
